// File: rtl/end_screen_sequencer.sv
// end_screen_sequencer
// Selects the pixel source for the OLED driver: gameplay pixels during play,
// then end screens 1, 2 and 3 after game over, with screen 3 blinking its text
// until the player presses continue. Screen changes only happen on frame_begin,
// so a single frame never mixes two screens. The output pixel register is fed
// from the next-state mux, so oled_data switches source in the same cycle that
// screen_sel does.

module end_screen_sequencer #(
    parameter int HOLD_FRAMES  = 60,
    parameter int BLINK_FRAMES = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_begin,
    input  logic        game_over,
    input  logic        btn_continue,
    input  logic [15:0] game_pix,
    input  logic [15:0] end_pix_1,
    input  logic [15:0] end_pix_2,
    input  logic [15:0] end_pix_3,
    output logic [15:0] oled_data,
    output logic [1:0]  screen_sel,
    output logic        end_active,
    output logic        done
);

    typedef enum logic [1:0] {
        PLAY = 2'd0,
        END1 = 2'd1,
        END2 = 2'd2,
        END3 = 2'd3
    } state_t;

    localparam logic [7:0] HOLD_LAST  = 8'(HOLD_FRAMES - 1);
    localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

    state_t      state;
    state_t      state_nx;
    logic [7:0]  fcnt;
    logic [7:0]  fcnt_nx;
    logic [7:0]  bcnt;
    logic [7:0]  bcnt_nx;
    logic        phase;
    logic        phase_nx;
    logic        go_pend;
    logic        go_pend_nx;
    logic        cont_pend;
    logic        cont_pend_nx;
    logic        done_nx;
    logic [15:0] pix_nx;

    // Next-state, counter and pending-flag logic; pulses that coincide with
    // frame_begin take effect at that same frame boundary.
    always_comb begin
        state_nx     = state;
        fcnt_nx      = fcnt;
        bcnt_nx      = bcnt;
        phase_nx     = phase;
        go_pend_nx   = go_pend;
        cont_pend_nx = cont_pend;
        done_nx      = 1'b0;
        case (state)
            PLAY: begin
                if (frame_begin && (go_pend || game_over)) begin
                    state_nx   = END1;
                    fcnt_nx    = 8'd0;
                    go_pend_nx = 1'b0;
                end else if (game_over) begin
                    go_pend_nx = 1'b1;
                end
            end
            END1, END2: begin
                if (frame_begin) begin
                    if (fcnt == HOLD_LAST) begin
                        fcnt_nx = 8'd0;
                        if (state == END1) begin
                            state_nx = END2;
                        end else begin
                            state_nx = END3;
                            bcnt_nx  = 8'd0;
                            phase_nx = 1'b0;
                        end
                    end else begin
                        fcnt_nx = fcnt + 8'd1;
                    end
                end
            end
            END3: begin
                if (frame_begin && (cont_pend || btn_continue)) begin
                    state_nx     = PLAY;
                    cont_pend_nx = 1'b0;
                    done_nx      = 1'b1;
                end else begin
                    if (btn_continue) begin
                        cont_pend_nx = 1'b1;
                    end
                    if (frame_begin) begin
                        if (bcnt == BLINK_LAST) begin
                            bcnt_nx  = 8'd0;
                            phase_nx = ~phase;
                        end else begin
                            bcnt_nx = bcnt + 8'd1;
                        end
                    end
                end
            end
            default: state_nx = PLAY;
        endcase
    end

    // Pixel source mux; in the blink-on phase black text becomes white.
    always_comb begin
        pix_nx = game_pix;
        case (state_nx)
            PLAY:    pix_nx = game_pix;
            END1:    pix_nx = end_pix_1;
            END2:    pix_nx = end_pix_2;
            END3:    pix_nx = (phase_nx && end_pix_3 == 16'h0000) ? 16'hFFFF : end_pix_3;
            default: pix_nx = game_pix;
        endcase
    end

    // State, counters, flags and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= PLAY;
            fcnt       <= 8'd0;
            bcnt       <= 8'd0;
            phase      <= 1'b0;
            go_pend    <= 1'b0;
            cont_pend  <= 1'b0;
            oled_data  <= 16'h0000;
            screen_sel <= 2'd0;
            end_active <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nx;
            fcnt       <= fcnt_nx;
            bcnt       <= bcnt_nx;
            phase      <= phase_nx;
            go_pend    <= go_pend_nx;
            cont_pend  <= cont_pend_nx;
            oled_data  <= pix_nx;
            screen_sel <= state_nx;
            end_active <= (state_nx != PLAY);
            done       <= done_nx;
        end
    end

endmodule

// File: tb/tb_end_screen_sequencer.sv
// Testbench for end_screen_sequencer with HOLD_FRAMES = 3, BLINK_FRAMES = 2.
// The reference model tracks "frames since game over was accepted" and derives
// the screen and blink phase from that count arithmetically.

module tb_end_screen_sequencer;

    localparam int H = 3;
    localparam int B = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_begin;
    logic        game_over;
    logic        btn_continue;
    logic [15:0] game_pix;
    logic [15:0] end_pix_1;
    logic [15:0] end_pix_2;
    logic [15:0] end_pix_3;
    logic [15:0] oled_data;
    logic [1:0]  screen_sel;
    logic        end_active;
    logic        done;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit          m_in_end;
    bit          m_go;
    bit          m_cont;
    int          m_k;
    logic [1:0]  exp_sel;
    logic [15:0] exp_pix;
    logic        exp_done;
    logic        exp_active;

    end_screen_sequencer #(
        .HOLD_FRAMES (H),
        .BLINK_FRAMES(B)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_begin (frame_begin),
        .game_over   (game_over),
        .btn_continue(btn_continue),
        .game_pix    (game_pix),
        .end_pix_1   (end_pix_1),
        .end_pix_2   (end_pix_2),
        .end_pix_3   (end_pix_3),
        .oled_data   (oled_data),
        .screen_sel  (screen_sel),
        .end_active  (end_active),
        .done        (done)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    task automatic model_reset();
        m_in_end   = 0;
        m_go       = 0;
        m_cont     = 0;
        m_k        = 0;
        exp_sel    = 2'd0;
        exp_pix    = 16'h0000;
        exp_done   = 1'b0;
        exp_active = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_edge();
        bit in_end3;
        int j;
        in_end3  = m_in_end && (m_k >= 2 * H);
        exp_done = 1'b0;
        if (!m_in_end) begin
            if (frame_begin && (m_go || game_over)) begin
                m_in_end = 1;
                m_k      = 0;
                m_go     = 0;
            end else if (game_over) begin
                m_go = 1;
            end
        end else if (in_end3 && frame_begin && (m_cont || btn_continue)) begin
            m_in_end = 0;
            m_cont   = 0;
            exp_done = 1'b1;
        end else begin
            if (in_end3 && btn_continue) m_cont = 1;
            if (frame_begin) m_k++;
        end
        exp_active = m_in_end;
        if (!m_in_end) begin
            exp_sel = 2'd0;
            exp_pix = game_pix;
        end else if (m_k < H) begin
            exp_sel = 2'd1;
            exp_pix = end_pix_1;
        end else if (m_k < 2 * H) begin
            exp_sel = 2'd2;
            exp_pix = end_pix_2;
        end else begin
            exp_sel = 2'd3;
            j = (m_k - 2 * H) / B;
            exp_pix = ((j % 2) == 1 && end_pix_3 == 16'h0000) ? 16'hFFFF : end_pix_3;
        end
    endtask

    // One clock: drive inputs at the falling edge, update the model at the
    // rising edge, return 1 ns later so outputs can be sampled.
    task automatic tick(input logic fb, input logic go, input logic btn);
        @(negedge clk);
        frame_begin  = fb;
        game_over    = go;
        btn_continue = btn;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        frame_begin  = 1'b0;
        game_over    = 1'b0;
        btn_continue = 1'b0;
        reset        = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        frame_begin  = 1'b0;
        game_over    = 1'b0;
        btn_continue = 1'b0;
        game_pix     = 16'h07E0;
        end_pix_1    = 16'hF800;
        end_pix_2    = 16'h001F;
        end_pix_3    = 16'h0000;
        reset        = 1'b1;
        #12;
        checks++;
        if ({oled_data, screen_sel, end_active, done} !== 20'h0) begin
            errors++;
            $display("[TB] FAIL reset_values: got pix=%h sel=%0d act=%b done=%b, want all zero",
                     oled_data, screen_sel, end_active, done);
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        tick(1'b0, 1'b0, 1'b0);
        checks++;
        if (oled_data !== 16'h07E0 || screen_sel !== 2'd0 || end_active !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL pass_through: got pix=%h sel=%0d act=%b done=%b, want pix=07e0 sel=0 act=0 done=0",
                     oled_data, screen_sel, end_active, done);
        end
        game_pix = 16'h1234;
        tick(1'b1, 1'b0, 1'b0);
        checks++;
        if (oled_data !== 16'h1234 || screen_sel !== 2'd0) begin
            errors++;
            $display("[TB] FAIL pass_through_fb: got pix=%h sel=%0d, want pix=1234 sel=0",
                     oled_data, screen_sel);
        end
    endtask

    task automatic test_full_sequence();
        logic [1:0]  sel_at[10];
        logic [15:0] pix_at[10];
        int          want_sel[10] = '{0, 1, 1, 1, 2, 2, 2, 3, 3, 3};
        logic [15:0] want_pix[10] = '{16'h07E0, 16'hF800, 16'hF800, 16'hF800, 16'h001F,
                                      16'h001F, 16'h001F, 16'h0000, 16'h0000, 16'hFFFF};
        do_reset();
        game_pix  = 16'h07E0;
        end_pix_1 = 16'hF800;
        end_pix_2 = 16'h001F;
        end_pix_3 = 16'h0000;
        for (int f = 0; f < 10; f++) begin
            for (int c = 0; c < 5; c++) begin
                // game_over mid-frame 0; btn_continue during END1 must be ignored
                tick(c == 0, f == 0 && c == 2, f == 2 && c == 3);
                checks++;
                if ({screen_sel, end_active, done, oled_data} !== {exp_sel, exp_active, exp_done, exp_pix}) begin
                    errors++;
                    $display("[TB] FAIL full_seq f%0d c%0d: got sel=%0d act=%b done=%b pix=%h, want sel=%0d act=%b done=%b pix=%h",
                             f, c, screen_sel, end_active, done, oled_data, exp_sel, exp_active, exp_done, exp_pix);
                end
                if (c == 0) begin
                    sel_at[f] = screen_sel;
                    pix_at[f] = oled_data;
                end
            end
        end
        for (int f = 0; f < 10; f++) begin
            checks++;
            if (sel_at[f] !== 2'(want_sel[f]) || pix_at[f] !== want_pix[f]) begin
                errors++;
                $display("[TB] FAIL full_seq_frame%0d: got sel=%0d pix=%h, want sel=%0d pix=%h",
                         f, sel_at[f], pix_at[f], want_sel[f], want_pix[f]);
            end
        end
    endtask

    task automatic test_blink();
        logic [15:0] want;
        do_reset();
        end_pix_3 = 16'h0000;
        for (int f = 0; f < 18; f++) begin
            if (f == 12) end_pix_3 = 16'hF81F;
            for (int c = 0; c < 4; c++) begin
                tick(c == 0, f == 0 && c == 0, 1'b0);
                checks++;
                if ({screen_sel, end_active, done, oled_data} !== {exp_sel, exp_active, exp_done, exp_pix}) begin
                    errors++;
                    $display("[TB] FAIL blink f%0d c%0d: got sel=%0d act=%b done=%b pix=%h, want sel=%0d act=%b done=%b pix=%h",
                             f, c, screen_sel, end_active, done, oled_data, exp_sel, exp_active, exp_done, exp_pix);
                end
                if (c == 0 && f >= 6) begin
                    want = (f >= 12) ? 16'hF81F : ((((f - 6) / 2) % 2) == 1 ? 16'hFFFF : 16'h0000);
                    checks++;
                    if (screen_sel !== 2'd3 || oled_data !== want) begin
                        errors++;
                        $display("[TB] FAIL blink_frame%0d: got sel=%0d pix=%h, want sel=3 pix=%h",
                                 f, screen_sel, oled_data, want);
                    end
                end
                if (f == 0 && c == 0) begin
                    checks++;
                    if (screen_sel !== 2'd1) begin
                        errors++;
                        $display("[TB] FAIL same_cycle_go: got sel=%0d, want sel=1", screen_sel);
                    end
                end
            end
        end
    endtask

    // Runs from END3 as left by test_blink.
    task automatic test_continue();
        game_pix = 16'h07E0;
        for (int c = 0; c < 4; c++) begin
            tick(c == 0, 1'b0, c == 2);
            checks++;
            if ({screen_sel, end_active, done, oled_data} !== {exp_sel, exp_active, exp_done, exp_pix}) begin
                errors++;
                $display("[TB] FAIL continue_wait c%0d: got sel=%0d act=%b done=%b pix=%h, want sel=%0d act=%b done=%b pix=%h",
                         c, screen_sel, end_active, done, oled_data, exp_sel, exp_active, exp_done, exp_pix);
            end
        end
        tick(1'b1, 1'b0, 1'b0);
        checks++;
        if (done !== 1'b1 || screen_sel !== 2'd0 || end_active !== 1'b0 || oled_data !== 16'h07E0) begin
            errors++;
            $display("[TB] FAIL continue_exit: got done=%b sel=%0d act=%b pix=%h, want done=1 sel=0 act=0 pix=07e0",
                     done, screen_sel, end_active, oled_data);
        end
        tick(1'b0, 1'b0, 1'b0);
        checks++;
        if (done !== 1'b0 || screen_sel !== 2'd0) begin
            errors++;
            $display("[TB] FAIL done_one_cycle: got done=%b sel=%0d, want done=0 sel=0", done, screen_sel);
        end
    endtask

    task automatic test_same_cycle();
        int want_sel[13] = '{1, 1, 1, 2, 2, 2, 3, 3, 3, 0, 0, 0, 0};
        do_reset();
        for (int f = 0; f < 13; f++) begin
            for (int c = 0; c < 4; c++) begin
                // extra game_over pulses during END2, one of them on frame_begin
                tick(c == 0, (f == 0 && c == 0) || (f == 4 && c == 1) || (f == 5 && c == 0), f == 8 && c == 2);
                checks++;
                if ({screen_sel, end_active, done, oled_data} !== {exp_sel, exp_active, exp_done, exp_pix}) begin
                    errors++;
                    $display("[TB] FAIL same_cycle f%0d c%0d: got sel=%0d act=%b done=%b pix=%h, want sel=%0d act=%b done=%b pix=%h",
                             f, c, screen_sel, end_active, done, oled_data, exp_sel, exp_active, exp_done, exp_pix);
                end
                if (c == 0) begin
                    checks++;
                    if (screen_sel !== 2'(want_sel[f])) begin
                        errors++;
                        $display("[TB] FAIL same_cycle_frame%0d: got sel=%0d, want sel=%0d",
                                 f, screen_sel, want_sel[f]);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        end_pix_2 = 16'h001F;
        game_pix  = 16'h07E0;
        for (int f = 0; f < 5; f++) begin
            for (int c = 0; c < 4; c++) begin
                if (f == 4 && c == 2) break;
                tick(c == 0, f == 0 && c == 0, 1'b0);
            end
        end
        checks++;
        if (screen_sel !== 2'd2 || oled_data !== 16'h001F) begin
            errors++;
            $display("[TB] FAIL reset_mid_pre: got sel=%0d pix=%h, want sel=2 pix=001f", screen_sel, oled_data);
        end
        @(negedge clk);
        frame_begin  = 1'b0;
        game_over    = 1'b0;
        btn_continue = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (oled_data !== 16'h0000 || screen_sel !== 2'd0 || end_active !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_async: got pix=%h sel=%0d act=%b, want pix=0000 sel=0 act=0",
                     oled_data, screen_sel, end_active);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        for (int f = 0; f < 3; f++) begin
            for (int c = 0; c < 4; c++) begin
                tick(c == 0, 1'b0, 1'b0);
                checks++;
                if (screen_sel !== 2'd0 || end_active !== 1'b0 || oled_data !== 16'h07E0) begin
                    errors++;
                    $display("[TB] FAIL reset_mid_stay f%0d c%0d: got sel=%0d act=%b pix=%h, want sel=0 act=0 pix=07e0",
                             f, c, screen_sel, end_active, oled_data);
                end
            end
        end
    endtask

    task automatic test_random();
        int flen = 5;
        int pos  = 0;
        logic fb;
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            fb = (pos == 0);
            pos++;
            if (pos >= flen) begin
                pos  = 0;
                flen = int'($urandom_range(9, 3));
            end
            game_pix  = 16'($urandom);
            end_pix_1 = 16'($urandom);
            end_pix_2 = 16'($urandom);
            end_pix_3 = ($urandom_range(1) == 0) ? 16'h0000 : 16'($urandom);
            tick(fb, $urandom_range(15) == 0, $urandom_range(7) == 0);
            checks++;
            if ({screen_sel, end_active, done, oled_data} !== {exp_sel, exp_active, exp_done, exp_pix}) begin
                errors++;
                $display("[TB] FAIL random i%0d: got sel=%0d act=%b done=%b pix=%h, want sel=%0d act=%b done=%b pix=%h",
                         i, screen_sel, end_active, done, oled_data, exp_sel, exp_active, exp_done, exp_pix);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_full_sequence();
        test_blink();
        test_continue();
        test_same_cycle();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
